// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: output-response-analyser state encoding and the
// default polynomial/seed constants also used by the pattern generator.
package lbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMPRESS = 2'd1,
        ST_COMPARE  = 2'd2,
        ST_DONE     = 2'd3
    } ora_state_t;

    localparam int         DEF_BITS = 3;
    localparam logic [2:0] DEF_POLY = 3'b011;
    localparam logic [2:0] DEF_SEED = 3'b000;

endpackage

// File: rtl/misr.sv
// Multiple-input signature register: loads SEED, folds one response word per
// enabled edge with internal XOR feedback from the top stage, otherwise holds.
module misr
    import lbist_pkg::*;
#(
    parameter int               BITS = DEF_BITS,
    parameter logic [BITS-1:0]  POLY = BITS'(DEF_POLY),
    parameter logic [BITS-1:0]  SEED = BITS'(DEF_SEED)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            fold,
    input  logic [BITS-1:0] resp,
    output logic [BITS-1:0] sig
);

    logic [BITS-1:0] sig_next;
    logic            msb;

    // Stage 0 always receives the feedback; POLY[0] is implicit and unused.
    always_comb begin
        msb         = sig[BITS-1];
        sig_next    = '0;
        sig_next[0] = msb ^ resp[0];
        for (int i = 1; i < BITS; i++) begin
            sig_next[i] = sig[i-1] ^ resp[i] ^ (POLY[i] & msb);
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours, exactly like the hardware shift chain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (fold) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/misr_ora.sv
// MISR-based output response analyser: compresses a session of CUT responses
// and compares the final signature against GOLDEN.
module misr_ora
    import lbist_pkg::*;
#(
    parameter int               BITS     = DEF_BITS,
    parameter int               PATTERNS = 7,
    parameter logic [BITS-1:0]  POLY     = BITS'(DEF_POLY),
    parameter logic [BITS-1:0]  SEED     = BITS'(DEF_SEED),
    parameter logic [BITS-1:0]  GOLDEN   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            resp_valid,
    input  logic [BITS-1:0] resp,
    input  logic            END,
    output logic [BITS-1:0] signature,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            fail
);

    localparam int CW = $clog2(PATTERNS + 1);

    ora_state_t    state, state_next;
    logic [CW-1:0] count;
    logic          load;
    logic          fold;
    logic          last_fold;

    misr #(
        .BITS (BITS),
        .POLY (POLY),
        .SEED (SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .fold (fold),
        .resp (resp),
        .sig  (signature)
    );

    assign last_fold = END || (count == CW'(PATTERNS - 1));

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        fold       = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_COMPRESS;
                end
            end
            ST_COMPRESS: begin
                if (resp_valid) begin
                    fold = 1'b1;
                    if (last_fold) state_next = ST_COMPARE;
                end
            end
            ST_COMPARE: state_next = ST_DONE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            count <= '0;
            pass  <= 1'b0;
            fail  <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                count <= '0;
            end else if (fold) begin
                count <= count + 1'b1;
            end
            // Verdict is captured once, on the edge that closes COMPARE.
            if (state == ST_COMPARE) begin
                pass <= (signature == GOLDEN);
                fail <= (signature != GOLDEN);
            end else if (load) begin
                pass <= 1'b0;
                fail <= 1'b0;
            end
        end
    end

    assign busy = (state == ST_COMPRESS) || (state == ST_COMPARE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_misr_ora.sv
// Scoreboard bench for misr_ora: two instances (short golden session and long
// END-terminated session) driven by directed and random sessions.
module tb_misr_ora;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i [2];
    logic       rv_i    [2];
    logic [2:0] resp_i  [2];
    logic       end_i   [2];
    logic [2:0] sig_o   [2];
    logic       busy_o  [2];
    logic       done_o  [2];
    logic       pass_o  [2];
    logic       fail_o  [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit armed = 1'b0;

    typedef struct {
        int         d;
        logic [2:0] sig;
        logic       pass_e;
        logic       fail_e;
        int         folds;
        int         cyc_e;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    misr_ora #(.BITS(3), .PATTERNS(2), .POLY(3'b011), .SEED(3'b000), .GOLDEN(3'b110)) dut_a (
        .clk(clk), .rst(rst), .start(start_i[0]), .resp_valid(rv_i[0]), .resp(resp_i[0]),
        .END(end_i[0]), .signature(sig_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .pass(pass_o[0]), .fail(fail_o[0]));

    misr_ora #(.BITS(3), .PATTERNS(7), .POLY(3'b011), .SEED(3'b100), .GOLDEN(3'b000)) dut_b (
        .clk(clk), .rst(rst), .start(start_i[1]), .resp_valid(rv_i[1]), .resp(resp_i[1]),
        .END(end_i[1]), .signature(sig_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .pass(pass_o[1]), .fail(fail_o[1]));

    function automatic logic [2:0] seed_of(int d);
        return (d == 0) ? 3'b000 : 3'b100;
    endfunction

    function automatic int pat_of(int d);
        return (d == 0) ? 2 : 7;
    endfunction

    function automatic logic [2:0] gold_of(int d);
        return (d == 0) ? 3'b110 : 3'b000;
    endfunction

    // Polynomial view: multiply by x modulo x^3 + POLY, then add the response.
    function automatic logic [2:0] fold_ref(logic [2:0] s, logic [2:0] r);
        logic [3:0] shifted;
        shifted = {s, 1'b0};
        return shifted[2:0] ^ r ^ (s[2] ? (3'b011 | 3'b001) : 3'b000);
    endfunction

    function automatic int count_of(int d);
        return (d == 0) ? int'(dut_a.count) : int'(dut_b.count);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(int d, logic st, logic v, logic [2:0] r, logic e);
        for (int k = 0; k < 2; k++) begin
            start_i[k] = 1'b0;
            rv_i[k]    = 1'b0;
            resp_i[k]  = 3'b000;
            end_i[k]   = 1'b0;
        end
        start_i[d] = st;
        rv_i[d]    = v;
        resp_i[d]  = r;
        end_i[d]   = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full session on instance d; responses come from rs, then random.
    task automatic session(int d, input logic [2:0] rs[$], int end_at, int max_gap);
        int         folds;
        int         gaps;
        logic [2:0] s;
        logic [2:0] r;
        exp_t       e;

        folds = pat_of(d);
        if (end_at >= 0 && end_at + 1 < folds) folds = end_at + 1;

        drive(d, 1'b1, 1'b0, 3'b000, 1'b0);
        tick();
        check("load_sig",  32'(sig_o[d]),  32'(seed_of(d)));
        check("load_busy", 32'(busy_o[d]), 32'd1);
        check("load_done", 32'(done_o[d]), 32'd0);

        s = seed_of(d);
        for (int i = 0; i < folds; i++) begin
            gaps = int'($urandom_range(0, max_gap));
            repeat (gaps) begin
                drive(d, 1'($urandom), 1'b0, 3'($urandom), 1'($urandom));
                tick();
            end
            r = (i < rs.size()) ? rs[i] : 3'($urandom);
            s = fold_ref(s, r);
            if (i == folds - 1) begin
                e.d      = d;
                e.sig    = s;
                e.pass_e = (s == gold_of(d));
                e.fail_e = (s != gold_of(d));
                e.folds  = folds;
                e.cyc_e  = cyc + 2;
                exp_q.push_back(e);
            end
            drive(d, 1'($urandom), 1'b1, r, (i == end_at));
            tick();
        end

        // Responses after the last fold must be ignored.
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            drive(d, 1'b0, 1'b1, 3'($urandom), 1'($urandom));
            tick();
        end
        check("done_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) begin
            drive(d, 1'b0, 1'b1, 3'($urandom), 1'($urandom));
            tick();
        end
        check("hold_sig",  32'(sig_o[d]),  32'(s));
        check("hold_done", 32'(done_o[d]), 32'd1);
        drive(d, 1'b0, 1'b0, 3'b000, 1'b0);
    endtask

    bit done_prev [2] = '{1'b0, 1'b0};

    // Monitor: invariants every cycle, scoreboard pop on each done rise.
    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                check("pf_exclusive", 32'(pass_o[d] & fail_o[d]), 32'd0);
                check("pf_outside_done", 32'(!done_o[d] && (pass_o[d] || fail_o[d])), 32'd0);
                if (done_o[d] && !done_prev[d]) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("sb_instance", 32'(d),          32'(e.d));
                        check("sb_signature", 32'(sig_o[d]),  32'(e.sig));
                        check("sb_pass",      32'(pass_o[d]), 32'(e.pass_e));
                        check("sb_fail",      32'(fail_o[d]), 32'(e.fail_e));
                        check("sb_count",     32'(count_of(d)), 32'(e.folds));
                        check("sb_latency",   32'(cyc),       32'(e.cyc_e));
                    end
                end
                done_prev[d] = done_o[d];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] qq[$];
        int         end_at;

        drive(0, 1'b0, 1'b0, 3'b000, 1'b0);
        drive(1, 1'b0, 1'b0, 3'b000, 1'b0);
        rst = 1'b0;
        repeat (2) tick();
        for (int d = 0; d < 2; d++) begin
            check("rst_sig",  32'(sig_o[d]),  32'(seed_of(d)));
            check("rst_busy", 32'(busy_o[d]), 32'd0);
            check("rst_done", 32'(done_o[d]), 32'd0);
            check("rst_pass", 32'(pass_o[d]), 32'd0);
            check("rst_fail", 32'(fail_o[d]), 32'd0);
        end
        rst   = 1'b1;
        armed = 1'b1;
        tick();

        // Golden 110 reached from 001,100; a different second word fails.
        qq = '{3'b001, 3'b100};
        session(0, qq, -1, 0);
        qq = '{3'b001, 3'b111};
        session(0, qq, -1, 0);
        qq = '{3'b001, 3'b100};
        session(0, qq, -1, 3);

        // Seed 100 with a zero response exercises the feedback taps.
        qq = '{3'b000};
        session(1, qq, 0, 0);
        qq.delete();
        session(1, qq, 2, 0);
        qq = '{3'b101, 3'b011, 3'b110, 3'b001, 3'b111, 3'b010, 3'b100};
        session(1, qq, -1, 0);
        session(1, qq, -1, 3);

        // Reset after one fold abandons the session; reset beats start.
        drive(1, 1'b1, 1'b0, 3'b000, 1'b0);
        tick();
        drive(1, 1'b0, 1'b1, 3'b101, 1'b0);
        tick();
        drive(1, 1'b1, 1'b0, 3'b000, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        drive(1, 1'b0, 1'b0, 3'b000, 1'b0);
        check("midrst_sig",  32'(sig_o[1]),  32'(seed_of(1)));
        check("midrst_busy", 32'(busy_o[1]), 32'd0);
        check("midrst_done", 32'(done_o[1]), 32'd0);
        check("midrst_cnt",  32'(count_of(1)), 32'd0);
        repeat (4) tick();
        check("midrst_idle", 32'(busy_o[1] | done_o[1]), 32'd0);
        qq.delete();
        session(1, qq, -1, 1);

        for (int n = 0; n < 30; n++) begin
            int d;
            d = n % 2;
            end_at = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, pat_of(d) - 1));
            qq.delete();
            session(d, qq, end_at, 2);
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/misr_ora.md
MISR_ORA -- requirements
Module: misr_ora

Interface
REQ-001 Parameter BITS, default 3, sets the response/signature width; legal range 2..32.
REQ-002 Parameter PATTERNS, default 7, sets the number of responses folded per session; legal range 1..2^BITS-1.
REQ-003 Parameter POLY, default 3'b011, gives feedback taps: bit i>=1 XORs sig[BITS-1] into stage i; bit 0 is ignored because the tap is implicit.
REQ-004 Parameter SEED, default 0, is the MISR load value at session start.
REQ-005 Parameter GOLDEN, default 0, is the expected final signature.
REQ-006 clk  input  1  the single clock; all logic is rising-edge.
REQ-007 rst  input  1  synchronous, active-low reset.
REQ-008 start  input  1  one-cycle pulse that begins a compression session.
REQ-009 resp_valid  input  1  qualifies resp for this cycle.
REQ-010 resp  input  BITS  CUT response word.
REQ-011 END  input  1  generator end-of-sequence flag; forces the last fold.
REQ-012 signature  output  BITS  current MISR contents.
REQ-013 busy  output  1  high while in COMPRESS or COMPARE.
REQ-014 done  output  1  high while in DONE.
REQ-015 pass  output  1  high in DONE when signature==GOLDEN.
REQ-016 fail  output  1  high in DONE when signature!=GOLDEN.

Function
REQ-017 The FSM SHALL have four states: IDLE, COMPRESS, COMPARE and DONE.
REQ-018 IDLE: start=1 loads SEED into the MISR, clears the counter, and moves to COMPRESS on the next edge.
REQ-019 COMPRESS: on each edge with resp_valid=1, the MISR folds resp and the counter increments; resp_valid=0 holds all state.
REQ-020 Fold rule: next[0]=sig[BITS-1]^resp[0]; for i>=1, next[i]=sig[i-1]^resp[i]^(POLY[i]&sig[BITS-1]).
REQ-021 The session SHALL leave COMPRESS for COMPARE on the edge that folds the PATTERNS-th valid response, or on any valid fold with END=1, whichever comes first.
REQ-022 END=1 with resp_valid=0 SHALL have no effect.
REQ-023 COMPARE lasts exactly one cycle; at its closing edge, pass and fail are registered and the FSM enters DONE.
REQ-024 done/pass/fail SHALL be asserted on the second edge after the last fold.
REQ-025 DONE: outputs and signature hold; start=1 reloads SEED, clears done/pass/fail, and enters COMPRESS.
REQ-026 start is ignored in COMPRESS and COMPARE; resp_valid is ignored outside COMPRESS.
REQ-027 The counter SHALL be $clog2(PATTERNS+1) bits wide and SHALL never wrap within a session.
REQ-028 pass and fail SHALL be mutually exclusive and both 0 outside DONE.

Reset
REQ-029 When rst=0 at an edge: state=IDLE, signature=SEED, counter=0, and busy=done=pass=fail=0.
REQ-030 Reset mid-session SHALL abandon the session with no pass/fail pulse; reset takes priority over start.

Structure
REQ-031 Package lbist_pkg SHALL hold the ora_state_t enum and the default POLY/SEED constants shared with rpg.
REQ-032 Sub-module misr (BITS, POLY, SEED) SHALL contain the shift register with load, fold and hold controls; the FSM and counter stay in misr_ora.

Verification
REQ-033 Defaults with GOLDEN=3'b110 and PATTERNS=2: start, then resp 001 -> sig 001, then resp 100 -> sig 110; two edges later done=1, pass=1.
REQ-034 Same stimulus with GOLDEN=3'b111 -> done=1, fail=1, pass=0.
REQ-035 SEED=3'b100 with resp 000 -> sig 011, which checks the POLY feedback.
REQ-036 PATTERNS=7 with END=1 on the 3rd valid response -> COMPARE after 3 folds and the counter reads 3.
REQ-037 Reset asserted after 1 fold -> sig=SEED, IDLE, no done; a subsequent start runs normally.
REQ-038 resp_valid gaps between folds give the same final signature as back-to-back folds; start during COMPRESS is ignored.
